// File: rtl/mux_scan_pipe.sv
// Registered channel multiplexer with a static-select mode and an
// auto-scan mode that walks every channel in turn and pulses wrap after
// the last one. All outputs come straight from flops.
module mux_scan_pipe #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 16,
   localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   input  logic                      en,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      sel_err,
   output logic                      wrap
);

   // Parameter sanity, checked once at elaboration.
   if (WIDTH < 1) begin : g_bad_width
      $error("mux_scan_pipe: WIDTH must be at least 1");
   end
   if (CHANNELS < 2) begin : g_bad_channels
      $error("mux_scan_pipe: CHANNELS must be at least 2");
   end

   // One extra bit so CHANNELS == 2**SEL_W still compares correctly.
   localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

   typedef enum logic {
      ST_STATIC = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [SEL_W-1:0] scan_cnt;
   logic [SEL_W-1:0] scan_cnt_next;
   logic [SEL_W-1:0] cap_ch;
   logic             cap_scan;
   logic             sel_ok;
   logic [WIDTH-1:0] ch_data;

   assign sel_ok = ({1'b0, sel} < CH_LIMIT);

   // Next state and capture decode; only consumed on enabled cycles.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_next    = state;
      scan_cnt_next = scan_cnt;
      cap_ch        = sel;
      cap_scan      = 1'b0;
      if (mode) begin
         state_next = ST_SCAN;
         cap_scan   = 1'b1;
         if (state == ST_STATIC) begin
            // Entering scan always starts from channel 0.
            cap_ch        = '0;
            scan_cnt_next = SEL_W'(1);
         end else begin
            cap_ch        = scan_cnt;
            scan_cnt_next = (scan_cnt == LAST_CH) ? '0 : scan_cnt + SEL_W'(1);
         end
      end else begin
         state_next = ST_STATIC;
      end
   end

   // Channel mux; an out-of-range index matches nothing and yields zero.
   always_comb begin
      ch_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (cap_ch == SEL_W'(k)) ch_data = in[k*WIDTH +: WIDTH];
      end
   end

   // Mode state register, advancing only on enabled cycles.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (reset)   state <= ST_STATIC;
      else if (en) state <= state_next;
   end

   // Capture registers: outputs and scan counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         sel_err   <= 1'b0;
         wrap      <= 1'b0;
         scan_cnt  <= '0;
      end else if (en) begin
         out_data  <= ch_data;
         out_valid <= 1'b1;
         out_ch    <= cap_ch;
         sel_err   <= !cap_scan && !sel_ok;
         wrap      <= cap_scan && (cap_ch == LAST_CH);
         scan_cnt  <= scan_cnt_next;
      end else begin
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_scan_pipe.sv
// Testbench for mux_scan_pipe: a 16-channel and a 12-channel instance share
// stimulus; a behavioural model predicts every output each cycle.
module tb_mux_scan_pipe;

   localparam int W   = 8;
   localparam int N16 = 16;
   localparam int N12 = 12;
   localparam int SW  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              en;
   logic              mode;
   logic [SW-1:0]     sel;
   logic [N16*W-1:0]  in16;
   logic [N12*W-1:0]  in12;

   logic [W-1:0]  a_data, b_data;
   logic          a_valid, b_valid;
   logic [SW-1:0] a_ch, b_ch;
   logic          a_err, b_err;
   logic          a_wrap, b_wrap;

   mux_scan_pipe #(.WIDTH(W), .CHANNELS(N16)) dut16 (
      .clk(clk), .reset(reset), .in(in16), .sel(sel), .mode(mode), .en(en),
      .out_data(a_data), .out_valid(a_valid), .out_ch(a_ch),
      .sel_err(a_err), .wrap(a_wrap));

   mux_scan_pipe #(.WIDTH(W), .CHANNELS(N12)) dut12 (
      .clk(clk), .reset(reset), .in(in12), .sel(sel), .mode(mode), .en(en),
      .out_data(b_data), .out_valid(b_valid), .out_ch(b_ch),
      .sel_err(b_err), .wrap(b_wrap));

   typedef struct packed {
      logic        scanning;
      logic [31:0] next_idx;
      logic [31:0] data;
      logic [31:0] ch;
      logic        valid;
      logic        err;
      logic        wrap;
   } model_t;

   int     ch_val [N16];
   model_t m16, m12;
   int     checks = 0;
   int     errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_in();
      for (int k = 0; k < N16; k++) in16[k*W +: W] = ch_val[k][W-1:0];
      for (int k = 0; k < N12; k++) in12[k*W +: W] = ch_val[k][W-1:0];
   endtask

   // Reference behaviour for n channels, applied to the inputs seen at an edge.
   function automatic model_t step(input model_t m, input int n);
      int idx;
      if (reset) begin
         m = '0;
      end else if (en) begin
         m.valid = 1'b1;
         if (mode) begin
            idx        = m.scanning ? int'(m.next_idx) : 0;
            m.scanning = 1'b1;
            m.next_idx = (idx + 1) % n;
            m.data     = ch_val[idx];
            m.ch       = idx;
            m.err      = 1'b0;
            m.wrap     = (idx == n - 1);
         end else begin
            m.scanning = 1'b0;
            m.ch       = {28'd0, sel};
            m.data     = (int'(sel) < n) ? ch_val[sel] : 0;
            m.err      = (int'(sel) >= n);
            m.wrap     = 1'b0;
         end
      end else begin
         m.valid = 1'b0;
         m.wrap  = 1'b0;
      end
      return m;
   endfunction

   // One clock: update the model at the edge, then compare both instances.
   task automatic tick(input string tag);
      @(posedge clk);
      m16 = step(m16, N16);
      m12 = step(m12, N12);
      #1;
      check({tag, "/a_data"},  {24'd0, a_data}, m16.data);
      check({tag, "/a_valid"}, {31'd0, a_valid}, {31'd0, m16.valid});
      check({tag, "/a_ch"},    {28'd0, a_ch},   m16.ch);
      check({tag, "/a_err"},   {31'd0, a_err},  {31'd0, m16.err});
      check({tag, "/a_wrap"},  {31'd0, a_wrap}, {31'd0, m16.wrap});
      check({tag, "/b_data"},  {24'd0, b_data}, m12.data);
      check({tag, "/b_valid"}, {31'd0, b_valid}, {31'd0, m12.valid});
      check({tag, "/b_ch"},    {28'd0, b_ch},   m12.ch);
      check({tag, "/b_err"},   {31'd0, b_err},  {31'd0, m12.err});
      check({tag, "/b_wrap"},  {31'd0, b_wrap}, {31'd0, m12.wrap});
   endtask

   initial begin
      m16 = '0;
      m12 = '0;
      reset = 1'b1; en = 1'b1; mode = 1'b1; sel = '0;
      for (int k = 0; k < N16; k++) ch_val[k] = k + 'h10;
      drive_in();

      // Reset wins even with en and mode high.
      tick("reset");
      check("reset_valid", {31'd0, a_valid}, 32'd0);
      check("reset_ch", {28'd0, a_ch}, 32'd0);
      reset = 1'b0;

      // Static sweep over every select value.
      mode = 1'b0;
      for (int s = 0; s < N16; s++) begin
         sel = SW'(s);
         tick("sweep");
         check("sweep_data", {24'd0, a_data}, 32'h10 + s);
         check("sweep_ch", {28'd0, a_ch}, s);
      end

      // Full scan: 0..15 then 0, wrap only alongside channel 15.
      mode = 1'b1;
      for (int i = 0; i <= N16; i++) begin
         tick("scan");
         check("scan_ch", {28'd0, a_ch}, i % N16);
         check("scan_wrap", {31'd0, a_wrap}, (i == N16 - 1) ? 32'd1 : 32'd0);
      end

      // Enable gap after reaching channel 5.
      for (int i = 1; i <= 5; i++) tick("to5");
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("gap");
         check("gap_valid", {31'd0, a_valid}, 32'd0);
         check("gap_ch", {28'd0, a_ch}, 32'd5);
      end
      en = 1'b1;
      tick("resume");
      check("resume_ch", {28'd0, a_ch}, 32'd6);

      // Illegal select on the 12-channel instance, then a legal one.
      mode = 1'b0; sel = 4'd13;
      tick("illegal");
      check("illegal_data", {24'd0, b_data}, 32'd0);
      check("illegal_err", {31'd0, b_err}, 32'd1);
      sel = 4'd3;
      tick("legal");
      check("legal_err", {31'd0, b_err}, 32'd0);
      check("legal_data", {24'd0, b_data}, 32'h13);

      // Reset in the middle of a scan.
      mode = 1'b1;
      for (int i = 0; i <= 9; i++) tick("to9");
      check("at9", {28'd0, a_ch}, 32'd9);
      reset = 1'b1;
      tick("midreset");
      check("midreset_ch", {28'd0, a_ch}, 32'd0);
      check("midreset_wrap", {31'd0, a_wrap}, 32'd0);
      reset = 1'b0;
      tick("after_reset");
      check("after_reset_ch", {28'd0, a_ch}, 32'd0);

      // Mode toggle: 4, static 10, then scan restarts at 0, 1.
      for (int i = 1; i <= 4; i++) tick("to4");
      mode = 1'b0; sel = 4'd10;
      tick("toggle_static");
      check("toggle_static_ch", {28'd0, a_ch}, 32'd10);
      mode = 1'b1;
      tick("toggle_scan0");
      check("toggle_scan0_ch", {28'd0, a_ch}, 32'd0);
      tick("toggle_scan1");
      check("toggle_scan1_ch", {28'd0, a_ch}, 32'd1);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         en    = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         sel   = SW'($urandom);
         reset = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < N16; k++) ch_val[k] = int'($urandom_range(0, 255));
            drive_in();
         end
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
